coin_intake: RTL and testbench

COIN_INTAKE -- requirements
Module: coin_intake

---
 rtl/coin_intake.sv | 133 +++++++++++++
 tb/tb_coin_intake.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/coin_intake.sv
// Coin slot front end: synchronizes the slot sensors, debounces one-hot
// insertions, strobes the accepted value and flushes jams.
module coin_intake #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [2:0] CoinSense,
  output logic [2:0] Coin,
  output logic       ModeEnable,
  output logic       Jam,
  output logic [7:0] CoinCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEB,
    S_ACC,
    S_REL,
    S_JAM
  } state_t;

  localparam logic [3:0] LP_LAST = 4'(DEBOUNCE_CYCLES - 1);

  logic [2:0] r_meta;
  logic [2:0] r_sync;
  state_t     r_state;
  logic [3:0] r_cnt;
  logic [2:0] r_cap;
  logic [7:0] r_count;

  state_t     w_state;
  logic [3:0] w_cnt;
  logic [2:0] w_cap;
  logic       w_onehot;

  assign w_onehot = (r_sync != 3'd0) &&
                    ((r_sync & (r_sync - 3'd1)) == 3'd0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_meta  <= '0;
      r_sync  <= '0;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cap   <= '0;
      r_count <= '0;
    end else begin
      r_meta  <= CoinSense;
      r_sync  <= r_meta;
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_cap   <= w_cap;
      if (r_state == S_ACC && r_count != 8'hFF)
        r_count <= r_count + 8'd1;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_cap   = r_cap;
    unique case (r_state)
      S_IDLE: begin
        if (w_onehot) begin
          w_state = S_DEB;
          w_cap   = r_sync;
          w_cnt   = 4'd1;
        end else if (r_sync != 3'd0) begin
          w_state = S_JAM;
          w_cnt   = 4'd0;
        end
      end
      S_DEB: begin
        if (r_sync == r_cap) begin
          if (r_cnt == LP_LAST) begin
            w_state = S_ACC;
            w_cnt   = 4'd0;
          end else begin
            w_cnt = r_cnt + 4'd1;
          end
        end else if (r_sync == 3'd0) begin
          w_state = S_IDLE;
          w_cnt   = 4'd0;
        end else begin
          w_state = S_JAM;
          w_cnt   = 4'd0;
        end
      end
      S_ACC: begin
        w_state = S_REL;
        w_cnt   = 4'd0;
      end
      // Slot must read clear for a full window before re-arming
      S_REL, S_JAM: begin
        if (r_sync != 3'd0) begin
          w_cnt = 4'd0;
        end else if (r_cnt == LP_LAST) begin
          w_state = S_IDLE;
          w_cnt   = 4'd0;
        end else begin
          w_cnt = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_cnt   = 4'd0;
      end
    endcase
  end

  always_comb begin
    Coin       = 3'd0;
    ModeEnable = 1'b0;
    Jam        = 1'b0;
    unique case (r_state)
      S_ACC: begin
        ModeEnable = 1'b1;
        unique case (1'b1)
          r_cap[2]: Coin = 3'd5;
          r_cap[1]: Coin = 3'd2;
          r_cap[0]: Coin = 3'd1;
          default:  Coin = 3'd0;
        endcase
      end
      S_JAM:   Jam = 1'b1;
      default: ;
    endcase
  end

  assign CoinCount = r_count;

endmodule

// File: tb/tb_coin_intake.sv
// Directed bench for coin_intake: latency, glitch, jam, sequence,
// saturation and reset-abort cases with hand-computed expectations.
module tb_coin_intake;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [2:0] CoinSense;
  logic [2:0] Coin;
  logic       ModeEnable;
  logic       Jam;
  logic [7:0] CoinCount;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_pulse  = 0;
  int pulse_cyc = -1;
  logic [2:0] coin_log [8];

  coin_intake #(.DEBOUNCE_CYCLES(4)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .CoinSense  (CoinSense),
    .Coin       (Coin),
    .ModeEnable (ModeEnable),
    .Jam        (Jam),
    .CoinCount  (CoinCount)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (ModeEnable === 1'b1) begin
      coin_log[n_pulse % 8] = Coin;
      pulse_cyc = cyc;
      n_pulse++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    Reset     = 1'b1;
    CoinSense = 3'd0;
    tick(n);
    Reset = 1'b0;
  endtask

  task automatic coin(input logic [2:0] v, input int hi, input int lo);
    CoinSense = v;
    tick(hi);
    CoinSense = 3'd0;
    tick(lo);
  endtask

  int base;
  int t0;
  int r;

  initial begin
    Reset     = 1'b1;
    CoinSense = 3'd0;

    // Reset state and single 5-unit coin latency
    do_reset(2);
    chk("rst_coin", 32'(Coin), 0);
    chk("rst_me", 32'(ModeEnable), 0);
    chk("rst_jam", 32'(Jam), 0);
    chk("rst_count", 32'(CoinCount), 0);
    base = n_pulse;
    CoinSense = 3'b100;
    t0 = cyc + 1;
    tick(10);
    CoinSense = 3'd0;
    tick(8);
    chk("c5_pulses", 32'(n_pulse - base), 1);
    chk("c5_cycle", 32'(pulse_cyc), 32'(t0 + 5));
    chk("c5_value", 32'(coin_log[base % 8]), 5);
    chk("c5_count", 32'(CoinCount), 1);

    // Two-cycle glitch is rejected, FSM back in IDLE
    do_reset(2);
    base = n_pulse;
    coin(3'b001, 2, 8);
    chk("glitch_pulses", 32'(n_pulse - base), 0);
    chk("glitch_count", 32'(CoinCount), 0);
    base = n_pulse;
    CoinSense = 3'b001;
    t0 = cyc + 1;
    tick(7);
    CoinSense = 3'd0;
    tick(8);
    chk("glitch_idle_cycle", 32'(pulse_cyc), 32'(t0 + 5));
    chk("glitch_idle_value", 32'(coin_log[base % 8]), 1);

    // Two sensors at once -> jam, then clear after four zero samples
    do_reset(2);
    base = n_pulse;
    CoinSense = 3'b011;
    tick(4);
    chk("jam_high", 32'(Jam), 1);
    tick(2);
    CoinSense = 3'd0;
    tick(5);
    chk("jam_still", 32'(Jam), 1);
    tick(1);
    chk("jam_clear", 32'(Jam), 0);
    chk("jam_pulses", 32'(n_pulse - base), 0);
    chk("jam_count", 32'(CoinCount), 0);

    // Coin sequence 1, 2, 5
    do_reset(2);
    base = n_pulse;
    coin(3'b001, 8, 8);
    coin(3'b010, 8, 8);
    coin(3'b100, 8, 8);
    chk("seq_pulses", 32'(n_pulse - base), 3);
    chk("seq_c0", 32'(coin_log[base % 8]), 1);
    chk("seq_c1", 32'(coin_log[(base + 1) % 8]), 2);
    chk("seq_c2", 32'(coin_log[(base + 2) % 8]), 5);
    chk("seq_count", 32'(CoinCount), 3);

    // Saturation at 255
    do_reset(2);
    base = n_pulse;
    for (int i = 0; i < 255; i++)
      coin(3'b010, 7, 7);
    chk("sat_pulses", 32'(n_pulse - base), 255);
    chk("sat_count", 32'(CoinCount), 255);
    base = n_pulse;
    coin(3'b100, 7, 7);
    chk("sat_extra_pulse", 32'(n_pulse - base), 1);
    chk("sat_hold", 32'(CoinCount), 255);

    // Reset mid-debounce: no credit, re-inserted from IDLE
    do_reset(2);
    base = n_pulse;
    CoinSense = 3'b010;
    tick(4);
    chk("abort_pre", 32'(n_pulse - base), 0);
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    r = cyc;
    chk("abort_rst_me", 32'(ModeEnable), 0);
    chk("abort_rst_count", 32'(CoinCount), 0);
    tick(12);
    CoinSense = 3'd0;
    tick(8);
    chk("abort_pulses", 32'(n_pulse - base), 1);
    chk("abort_cycle", 32'(pulse_cyc), 32'(r + 6));
    chk("abort_value", 32'(coin_log[base % 8]), 2);
    chk("abort_count", 32'(CoinCount), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
